// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port BRAM between the core's instruction-fetch port
//   (imem_*) and its load/store port (dmem_*). Requests are serialized, each
//   access is issued to memory as a one-cycle registered strobe, and the
//   response is routed back to the granted port. Accesses that the memory
//   never answers are ended by a watchdog with an error response.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_read/imem_addr   fetch request (held through its resp cycle)
//   imem_rdata/imem_resp  fetch data and one-cycle completion pulse
//   dmem_read/dmem_write  data request (held through its resp cycle)
//   dmem_addr/wdata/be    data address, store data, store byte enables
//   dmem_rdata/dmem_resp  load data and one-cycle completion pulse
//   mem_read/mem_write    registered one-cycle memory strobes
//   mem_addr/wdata/be     registered memory address, store data, byte enables
//   mem_rdata/mem_resp    memory read data and completion pulse
//   bus_err               pulses with a timed-out response
//   err_addr              address of the most recent timed-out access
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_read,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state_reg, state_next;
  logic        grant_reg;
  logic        last_grant_reg;
  logic [7:0]  wdog_reg;
  logic        mem_read_reg, mem_write_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] err_addr_reg;

  logic        data_req;
  logic        any_req;
  logic        pick_data;
  logic        data_is_write;
  logic        in_wait;
  logic        timeout_hit;
  logic        access_done;
  logic [3:0]  store_be;

  assign data_req      = dmem_read | dmem_write;
  assign any_req       = data_req | imem_read;
  // Data wins when it is alone, or on a tie when the fetch port went last.
  assign pick_data     = data_req & (~imem_read | (last_grant_reg == GRANT_INST));
  // Read and write together is treated as a write.
  assign data_is_write = pick_data & dmem_write;

  // Byte enables only reach memory for stores; reads always carry 4'b0000.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_store_be
      assign store_be[gi] = dmem_write & dmem_be[gi];
    end
  endgenerate

  assign in_wait     = (state_reg == ST_WAIT);
  // A response arriving on the deadline cycle wins over the timeout.
  assign timeout_hit = in_wait & (wdog_reg == TIMEOUT_LIMIT) & ~mem_resp;
  assign access_done = in_wait & (mem_resp | timeout_hit);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (any_req) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (access_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= GRANT_INST;
      last_grant_reg <= GRANT_INST;
      wdog_reg       <= 8'd0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= 32'd0;
      mem_wdata_reg  <= 32'd0;
      mem_be_reg     <= 4'd0;
      err_addr_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      // Strobes are high only during the ISSUE cycle.
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            grant_reg      <= pick_data ? GRANT_DATA : GRANT_INST;
            last_grant_reg <= pick_data ? GRANT_DATA : GRANT_INST;
            mem_addr_reg   <= pick_data ? dmem_addr : imem_addr;
            mem_wdata_reg  <= pick_data ? dmem_wdata : 32'd0;
            mem_be_reg     <= pick_data ? store_be : 4'd0;
            mem_read_reg   <= ~data_is_write;
            mem_write_reg  <= data_is_write;
            wdog_reg       <= 8'd0;
          end
        end
        // Watchdog is 0 during ISSUE and counts from here, so the first
        // WAIT cycle sees a count of 1.
        ST_ISSUE: wdog_reg <= 8'd1;
        ST_WAIT: begin
          if (wdog_reg != 8'hFF) wdog_reg <= wdog_reg + 8'd1;
          if (timeout_hit) err_addr_reg <= mem_addr_reg;
        end
        default: ;
      endcase
    end
  end

  assign imem_resp  = access_done & (grant_reg == GRANT_INST);
  assign dmem_resp  = access_done & (grant_reg == GRANT_DATA);
  assign imem_rdata = (in_wait & mem_resp & (grant_reg == GRANT_INST)) ? mem_rdata : 32'd0;
  assign dmem_rdata = (in_wait & mem_resp & (grant_reg == GRANT_DATA)) ? mem_rdata : 32'd0;
  assign bus_err    = timeout_hit;

  assign mem_read   = mem_read_reg;
  assign mem_write  = mem_write_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_be     = mem_be_reg;
  assign err_addr   = err_addr_reg;

endmodule
